// File: rtl/lmh6401_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : lmh6401_pkg                                                |
// | Description : Shared constants and types for the LMH6401 SPI responder:  |
// |               frame length, bit-counter limits, receive FSM state type   |
// |               and the bit positions inside error_out.                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package lmh6401_pkg;

  localparam int FRAME_BITS = 16;

  // bit_cnt is 5 bits and saturates one past a full frame, so overlong
  // frames can never wrap back to look like a legal 16-bit frame.
  localparam int         BIT_CNT_W   = 5;
  localparam logic [4:0] BIT_CNT_MAX = 5'd17;

  localparam int ERR_BAD_LENGTH = 0;
  localparam int ERR_MULTI_CS   = 1;
  localparam int ERR_OVERFLOW   = 2;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SHIFT     = 2'd2,
    ST_ABORT     = 2'd3
  } rx_state_e;

endpackage : lmh6401_pkg
`default_nettype wire

// File: rtl/spi_input_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_input_sync                                             |
// | Description : SYNC_STAGES-deep flip-flop synchronizer for a bus of       |
// |               asynchronous SPI pins, plus a "primed" flag that rises     |
// |               once every stage holds a sample taken after reset.         |
// | Revision    : 1.0  initial release                                       |
// | Ports       : clk, reset  - system clock, sync active-high reset         |
// |               din         - raw asynchronous inputs                      |
// |               dout        - synchronized inputs                          |
// |               primed      - chain filled with post-reset samples         |
// +--------------------------------------------------------------------------+
module spi_input_sync #(
  parameter int               WIDTH       = 6,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             primed
);

  logic [WIDTH-1:0]       stage_q [SYNC_STAGES];
  logic [WIDTH-1:0]       stage_d [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [SYNC_STAGES-1:0] fill_d;

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
      fill_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      fill_q <= fill_d;
    end
  end

  assign dout   = stage_q[SYNC_STAGES-1];
  assign primed = fill_q[SYNC_STAGES-1];

endmodule : spi_input_sync
`default_nettype wire

// File: rtl/lmh6401_spi_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lmh6401_spi_rx                                             |
// | Description : Oversampling SPI responder for the LMH6401 gain-control    |
// |               master. Each completed 16-bit CS-per-device frame becomes  |
// |               one stream word {channel, frame}. Nothing runs on sck.     |
// | Revision    : 1.0  initial release                                       |
// | Macro       : LMH6401_SPI_RX_ERR_EN - drive error_out; when undefined    |
// |               error_out is tied to zero.                                 |
// | Ports       : clk, reset            - system clock, sync reset (high)    |
// |               spi_sck/sdi/cs_n      - SPI inputs (responder side)        |
// |               word_out_valid/ready  - stream handshake                   |
// |               word_out_data         - {channel, frame[15:0]}             |
// |               error_out             - {overflow, multi_cs, bad_length}   |
// +--------------------------------------------------------------------------+
module lmh6401_spi_rx
  import lmh6401_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       spi_sck,
  input  logic                                       spi_sdi,
  input  logic [NUM_CHANNELS-1:0]                    spi_cs_n,
  output logic                                       word_out_valid,
  input  logic                                       word_out_ready,
  output logic [$clog2(NUM_CHANNELS)+FRAME_BITS-1:0] word_out_data,
  output logic [2:0]                                 error_out
);

  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int DW   = CH_W + FRAME_BITS;
  localparam int SW   = NUM_CHANNELS + 2;
  // cs_n idles high, sck/sdi idle low.
  localparam logic [SW-1:0] SYNC_RST = {{NUM_CHANNELS{1'b1}}, 2'b00};

  logic [SW-1:0]           sync_bus;
  logic                    sync_primed;
  logic                    sck_s, sdi_s;
  logic [NUM_CHANNELS-1:0] cs_s;

  spi_input_sync #(
    .WIDTH      (SW),
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (SYNC_RST)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   ({spi_cs_n, spi_sdi, spi_sck}),
    .dout  (sync_bus),
    .primed(sync_primed)
  );

  assign {cs_s, sdi_s, sck_s} = sync_bus;

  rx_state_e             state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  sck_prev_q, sck_prev_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  sck_rise;

  assign sck_prev_d = sck_s;
  assign sck_rise   = sck_s & ~sck_prev_q;

  // Classify the synchronized chip selects.
  logic            any_low, multi_low, other_low;
  logic [CH_W-1:0] low_idx;

  always_comb begin
    any_low   = 1'b0;
    multi_low = 1'b0;
    other_low = 1'b0;
    low_idx   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (!cs_s[i]) begin
        if (any_low) multi_low = 1'b1;
        any_low = 1'b1;
        low_idx = CH_W'(i);
        if (CH_W'(i) != ch_q) other_low = 1'b1;
      end
    end
  end

`ifdef LMH6401_SPI_RX_ERR_EN
  logic       bad_len_det, multi_det;
  logic [2:0] err_q, err_d;
`endif

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
`ifdef LMH6401_SPI_RX_ERR_EN
    bad_len_det = 1'b0;
    multi_det   = 1'b0;
`endif
    case (state_q)
      // Wait for the synchronizer to hold real samples so a frame cut by
      // reset is never mistaken for the start of a new one.
      ST_WAIT_IDLE: begin
        if (sync_primed && !any_low) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (multi_low) begin
`ifdef LMH6401_SPI_RX_ERR_EN
          multi_det = 1'b1;
`endif
          state_d = ST_ABORT;
        end else if (any_low) begin
          ch_d      = low_idx;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (other_low) begin
`ifdef LMH6401_SPI_RX_ERR_EN
          multi_det = 1'b1;
`endif
          state_d = ST_ABORT;
        end else if (cs_s[ch_q]) begin
          if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS)) begin
            done_d = 1'b1;
          end else begin
`ifdef LMH6401_SPI_RX_ERR_EN
            bad_len_det = 1'b1;
`endif
          end
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          frame_d = {frame_q[FRAME_BITS-2:0], sdi_s};
          if (bit_cnt_q != BIT_CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_ABORT: begin
        if (!any_low) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  // One-entry holding register. done_q follows the FSM by one cycle; ch_q
  // and frame_q are still stable then because the next frame needs cs_n
  // setup time before anything is latched again.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && word_out_ready) valid_d = 1'b0;
    if (done_q && (!valid_q || word_out_ready)) begin
      valid_d = 1'b1;
      data_d  = {ch_q, frame_q};
    end
`ifdef LMH6401_SPI_RX_ERR_EN
    err_d                 = '0;
    err_d[ERR_BAD_LENGTH] = bad_len_det;
    err_d[ERR_MULTI_CS]   = multi_det;
    err_d[ERR_OVERFLOW]   = done_q && valid_q && !word_out_ready;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT_IDLE;
      ch_q       <= '0;
      bit_cnt_q  <= '0;
      frame_q    <= '0;
      sck_prev_q <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
`ifdef LMH6401_SPI_RX_ERR_EN
      err_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      sck_prev_q <= sck_prev_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
`ifdef LMH6401_SPI_RX_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign word_out_valid = valid_q;
  assign word_out_data  = data_q;
`ifdef LMH6401_SPI_RX_ERR_EN
  assign error_out = err_q;
`else
  assign error_out = 3'b000;
`endif

endmodule : lmh6401_spi_rx
`default_nettype wire

// File: tb/tb_lmh6401_spi_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lmh6401_spi_rx                                          |
// | Description : Self-checking bench for lmh6401_spi_rx. A behavioural SPI  |
// |               master drives frames; expected words and error pulses are  |
// |               derived from the frame rules (length, chip-select, ready). |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_lmh6401_spi_rx;

  localparam int NCH = 4;
  localparam int SS  = 2;
  localparam int DW  = 18;
`ifdef LMH6401_SPI_RX_ERR_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           spi_sck = 1'b0;
  logic           spi_sdi = 1'b0;
  logic [NCH-1:0] spi_cs_n = '1;
  logic           word_out_valid;
  logic           word_out_ready = 1'b1;
  logic [DW-1:0]  word_out_data;
  logic [2:0]     error_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] got_q[$];
  int            err_cnt[3];

  lmh6401_spi_rx #(.NUM_CHANNELS(NCH), .SYNC_STAGES(SS)) dut (
    .clk           (clk),
    .reset         (reset),
    .spi_sck       (spi_sck),
    .spi_sdi       (spi_sdi),
    .spi_cs_n      (spi_cs_n),
    .word_out_valid(word_out_valid),
    .word_out_ready(word_out_ready),
    .word_out_data (word_out_data),
    .error_out     (error_out)
  );

  always #5 clk = ~clk;

  // Record accepted words and error pulses (values just before each edge).
  initial begin
    err_cnt[0] = 0; err_cnt[1] = 0; err_cnt[2] = 0;
  end
  always @(posedge clk) begin
    if (!reset) begin
      if (word_out_valid && word_out_ready) got_q.push_back(word_out_data);
      for (int b = 0; b < 3; b++) if (error_out[b]) err_cnt[b]++;
    end
  end

  // ---------------- behavioural SPI master ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low(input int ch);
    spi_cs_n[ch] = 1'b0;
    wait_clks(5);
  endtask

  task automatic shift_bit(input logic b);
    spi_sdi = b;
    wait_clks(5);
    spi_sck = 1'b1;
    wait_clks(5);
    spi_sck = 1'b0;
  endtask

  task automatic cs_high(input int ch);
    wait_clks(5);
    spi_cs_n[ch] = 1'b1;
  endtask

  task automatic send_frame(input int ch, input logic [15:0] d, input int nbits);
    cs_low(ch);
    for (int i = 0; i < nbits; i++) shift_bit(i < 16 ? d[15-i] : 1'b0);
    cs_high(ch);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    wait_clks(4);
    n_checks++; if (word_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", word_out_valid); end
    n_checks++; if (word_out_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", word_out_data); end
    n_checks++; if (error_out !== 3'b000) begin n_fail++; $display("FAIL reset_err got=%b exp=000", error_out); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({word_out_valid, word_out_data, error_out} !== '0) begin
      n_fail++; $display("FAIL post_reset_outputs got=%h exp=0", {word_out_valid, word_out_data, error_out});
    end
    wait_clks(6);
  endtask

  task automatic test_directed_latency;
    int k;
    got_q.delete();
    send_frame(2, 16'h5A3C, 16);
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (word_out_valid) break;
    end
    n_checks++; if (k !== SS + 2) begin n_fail++; $display("FAIL latency got=%0d exp=%0d", k, SS + 2); end
    n_checks++; if (word_out_data !== {2'd2, 16'h5A3C}) begin n_fail++; $display("FAIL directed_data got=%h exp=%h", word_out_data, {2'd2, 16'h5A3C}); end
    wait_clks(8);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL directed_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_bad_length;
    int b0;
    b0 = err_cnt[0];
    got_q.delete();
    send_frame(1, 16'hFFFF, 15); wait_clks(8);
    send_frame(1, 16'hFFFF, 17); wait_clks(8);
    send_frame(1, 16'h0001, 16); wait_clks(8);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL badlen_count got=%0d exp=1", got_q.size()); end
    n_checks++; if ((got_q.size() > 0 ? got_q[0] : 'x) !== {2'd1, 16'h0001}) begin
      n_fail++; $display("FAIL badlen_next_word got=%h exp=%h", (got_q.size() > 0 ? got_q[0] : 'x), {2'd1, 16'h0001});
    end
    n_checks++; if (err_cnt[0] - b0 !== 2 * ERR_EN) begin n_fail++; $display("FAIL badlen_pulses got=%0d exp=%0d", err_cnt[0] - b0, 2 * ERR_EN); end
  endtask

  task automatic test_multi_cs;
    int m0, b0;
    logic [15:0] d;
    m0 = err_cnt[1]; b0 = err_cnt[0];
    got_q.delete();
    cs_low(0);
    for (int i = 0; i < 8; i++) shift_bit(1'($urandom));
    spi_cs_n[3] = 1'b0;
    wait_clks(10);
    spi_cs_n = '1;
    wait_clks(8);
    d = 16'($urandom);
    send_frame(3, d, 16); wait_clks(8);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL multi_count got=%0d exp=1", got_q.size()); end
    n_checks++; if ((got_q.size() > 0 ? got_q[0] : 'x) !== {2'd3, d}) begin
      n_fail++; $display("FAIL multi_next_word got=%h exp=%h", (got_q.size() > 0 ? got_q[0] : 'x), {2'd3, d});
    end
    n_checks++; if (err_cnt[1] - m0 !== ERR_EN) begin n_fail++; $display("FAIL multi_pulses got=%0d exp=%0d", err_cnt[1] - m0, ERR_EN); end
    n_checks++; if (err_cnt[0] - b0 !== 0) begin n_fail++; $display("FAIL multi_badlen got=%0d exp=0", err_cnt[0] - b0); end
  endtask

  task automatic test_overflow;
    int o0;
    o0 = err_cnt[2];
    got_q.delete();
    word_out_ready = 1'b0;
    send_frame(0, 16'h1111, 16); wait_clks(8);
    send_frame(1, 16'h2222, 16); wait_clks(8);
    n_checks++; if (word_out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got=%b exp=1", word_out_valid); end
    n_checks++; if (word_out_data !== {2'd0, 16'h1111}) begin n_fail++; $display("FAIL ovf_held got=%h exp=%h", word_out_data, {2'd0, 16'h1111}); end
    n_checks++; if (err_cnt[2] - o0 !== ERR_EN) begin n_fail++; $display("FAIL ovf_pulses got=%0d exp=%0d", err_cnt[2] - o0, ERR_EN); end
    word_out_ready = 1'b1;
    wait_clks(20);
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL ovf_count got=%0d exp=1", got_q.size()); end
    n_checks++; if ((got_q.size() > 0 ? got_q[0] : 'x) !== {2'd0, 16'h1111}) begin
      n_fail++; $display("FAIL ovf_delivered got=%h exp=%h", (got_q.size() > 0 ? got_q[0] : 'x), {2'd0, 16'h1111});
    end
    n_checks++; if (word_out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got=%b exp=0", word_out_valid); end
  endtask

  task automatic test_reset_mid_frame;
    int e0;
    logic [15:0] d;
    e0 = err_cnt[0] + err_cnt[1] + err_cnt[2];
    got_q.delete();
    cs_low(1);
    for (int i = 0; i < 8; i++) shift_bit(1'($urandom));
    reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({word_out_valid, word_out_data, error_out} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs got=%h exp=0", {word_out_valid, word_out_data, error_out});
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) shift_bit(1'($urandom));
    cs_high(1);
    wait_clks(10);
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL midreset_dropped got=%0d exp=0", got_q.size()); end
    n_checks++; if (err_cnt[0] + err_cnt[1] + err_cnt[2] - e0 !== 0) begin
      n_fail++; $display("FAIL midreset_errors got=%0d exp=0", err_cnt[0] + err_cnt[1] + err_cnt[2] - e0);
    end
    d = 16'($urandom);
    send_frame(0, d, 16); wait_clks(8);
    n_checks++; if ((got_q.size() > 0 ? got_q[0] : 'x) !== {2'd0, d}) begin
      n_fail++; $display("FAIL midreset_next_word got=%h exp=%h", (got_q.size() > 0 ? got_q[0] : 'x), {2'd0, d});
    end
  endtask

  // Random frames: legal 16-bit frames must all appear in order; 15/17-bit
  // frames are dropped and (with errors enabled) flagged once each.
  task automatic test_random(input int n, input bit vary_len, input bit cmd_only);
    logic [DW-1:0] exp_q[$];
    int            exp_bad, e0, b0;
    int            ch, len, r;
    logic [15:0]   d;
    exp_bad = 0;
    e0 = err_cnt[1] + err_cnt[2];
    b0 = err_cnt[0];
    got_q.delete();
    for (int f = 0; f < n; f++) begin
      ch = $urandom_range(0, NCH - 1);
      d  = 16'($urandom);
      if (cmd_only) d[15] = 1'b0;
      len = 16;
      if (vary_len) begin
        r = $urandom_range(0, 3);
        len = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      end
      if (len == 16) exp_q.push_back({2'(ch), d});
      else exp_bad++;
      send_frame(ch, d, len);
      wait_clks($urandom_range(6, 12));
    end
    wait_clks(10);
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if ((i < got_q.size() ? got_q[i] : 'x) !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_word[%0d] got=%h exp=%h", i, (i < got_q.size() ? got_q[i] : 'x), exp_q[i]);
      end
    end
    n_checks++; if (err_cnt[0] - b0 !== exp_bad * ERR_EN) begin n_fail++; $display("FAIL rand_badlen got=%0d exp=%0d", err_cnt[0] - b0, exp_bad * ERR_EN); end
    n_checks++; if (err_cnt[1] + err_cnt[2] - e0 !== 0) begin n_fail++; $display("FAIL rand_other_err got=%0d exp=0", err_cnt[1] + err_cnt[2] - e0); end
  endtask

  initial begin
    test_reset();
    test_directed_latency();
    test_bad_length();
    test_multi_cs();
    test_overflow();
    test_reset_mid_frame();
    test_random(120, 1'b0, 1'b1);
    test_random(40, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lmh6401_spi_rx
`default_nettype wire
